surf_trig_deframer: RTL and testbench
=====================================

# surf_trig_deframer

Upstream stage of the master trigger processor, in the sysclk domain. It takes the raw 16-bit SURF trigger words from all 32 TURFIO ports and drops the four unused ports, leaving 28 real lanes. For each 4-clock trigger slot it pairs each lane's trigger word with its metadata word, checks framing, and applies the lane mask. It presents one aligned, qualified snapshot per slot and keeps framing-error statistics for trigger control.

## Interface
Parameters:
- NSURF, 32, physical input ports (4 TURFIOs × 8).
- SURFS_PER_TIO, 8, ports per TURFIO.
- REAL_SURFS_PER_TIO, 7, populated ports per TURFIO; output lane count NREAL = 4×7 = 28.

Ports:
- sysclk_i  in  1  system clock; the only clock.
- sysclk_rst_i  in  1  synchronous, active-high reset.
- slot_start_i  in  1  marks clock 0 of a 4-clock trigger slot.
- trig_dat_i  in  NSURF*16  raw SURF words; port p occupies [16p +: 16].
- trig_dat_valid_i  in  NSURF  per-port link valid.
- lane_mask_i  in  28  1 = lane masked (forced idle, never errors).
- err_clear_i  in  1  clears err_count_o and err_lanes_o.
- trig_o  out  28*12  per-lane trigger field (word0[11:0]).
- trig_meta_o  out  28*8  per-lane metadata (word1[7:0]).
- trig_hit_o  out  28  lane carried a valid trigger this slot.
- trig_valid_o  out  1  one-clock strobe; outputs above are valid.
- err_count_o  out  16  saturating count of lane framing errors.
- err_lanes_o  out  28  sticky per-lane error flags.
- slot_err_o  out  1  sticky; slot_start_i arrived while word1 was expected.

## Operation
- Lane map: real lane r = 7t + s (t = 0..3, s = 0..6) takes input port 8t + s. Ports 7, 15, 23 and 31 are ignored.
- Slot capture:
  - The cycle with slot_start_i high captures word0 from every lane.
  - The next cycle captures word1.
  - Slot clocks 2 and 3 are ignored.
- Per-lane classification, for an unmasked lane with trig_dat_valid_i high in both capture cycles:
  - word0 == 0x0000 and word1 == 0x0000: idle. hit = 0, no error.
  - word0[15] = 1 and word1[15] = 0: trigger. hit = 1, trig = word0[11:0], meta = word1[7:0]. Bits word0[14:12] and word1[14:8] are ignored.
  - Anything else: framing error. hit = 0, trig and meta are zero, err_lanes_o[r] is set.
- Masked lane, or trig_dat_valid_i low in either capture cycle: forced idle with no error.
- Error count: err_count_o += popcount(lanes in error this slot), saturating at 0xFFFF and never wrapping.
- err_clear_i:
  - Zeroes err_count_o, err_lanes_o and slot_err_o on the next edge.
  - If it coincides with an error update, the clear wins and that slot's errors are discarded.
- Early restart: slot_start_i high in the cycle where word1 was expected means:
  - the pending slot is discarded and no trig_valid_o is produced for it;
  - slot_err_o is set;
  - the current word is taken as word0 of a new slot.
- Lane masking is applied at word1 capture. Mask changes mid-slot take effect from the next slot's word1.

## Timing
- Slot start at cycle T (word0); word1 at T+1.
- Registered outputs and trig_valid_o appear at T+2. trig_valid_o is high for exactly one clock.
- trig_o, trig_meta_o and trig_hit_o hold until the next trig_valid_o.
- err_lanes_o and err_count_o update at T+2, coincident with trig_valid_o.
- Nominal slot period is 4 clocks; periods of 2 or more are accepted. A period of 1 is an early restart.
- Reset values: all outputs 0; capture state idle (waiting for slot_start_i). Reset mid-slot discards the slot, and no strobe follows.

## Structure
- Package pueo_trig_in_pkg holds:
  - constants NREAL = 28, TRIG_FLAG_BIT = 15, TRIG_W = 12, META_W = 8;
  - the lane-to-port map function;
  - the lane status enum {IDLE, HIT, FERR}.
- Sub-module surf_trig_lane_deframer (one per real lane): word0/word1 capture and classification, with status, trig and meta outputs.
- The top level holds the slot sequencer (states IDLE, W1), the output register, the 28-input popcount feeding the saturating counter, and the sticky flags.

## Test plan
- Idle: all lanes 0x0000 with slot_start_i every 4 clocks -> trig_valid_o at T+2 every slot, trig_hit_o = 0, err_count_o = 0.
- Trigger on lane 8 (port 9): word0 0x8ABC, word1 0x005A -> trig_hit_o[8] = 1, trig_o lane 8 = 0xABC, trig_meta_o = 0x5A; port 7 driven 0x8FFF has no effect.
- Framing: lane 3 word0 0x1234 and lane 20 word1 0x8001 -> err_lanes_o bits 3 and 20 set, err_count_o += 2, both hits 0.
- Mask and valid: lane 3 masked or its trig_dat_valid_i low with bad data -> no error, hit 0. err_count_o preloaded to 0xFFFE, then a 28-lane error slot -> 0xFFFF.
- slot_start_i on consecutive clocks -> slot_err_o = 1, one strobe 2 clocks after the second start. err_clear_i coinciding with an error slot -> all statistics 0.
- sysclk_rst_i asserted at T+1 -> no strobe at T+2, all outputs 0; the next slot after release behaves normally.

Source files
------------

// File: rtl/surf_trig_deframer_pkg.sv
// pueo_trig_in_pkg: shared constants, lane status type, slot sequencer
// states and the real-lane to physical-port map for the SURF trigger
// deframer.
// Ports: none (package).
package pueo_trig_in_pkg;

    localparam int NREAL         = 28;
    localparam int TRIG_FLAG_BIT = 15;
    localparam int TRIG_W        = 12;
    localparam int META_W        = 8;

    typedef enum logic [1:0] {
        IDLE,
        HIT,
        FERR
    } lane_status_t;

    typedef enum logic {
        ST_IDLE,
        ST_W1
    } slot_state_t;

    // Real lane r = real_per_tio*t + s lives on physical port per_tio*t + s;
    // the trailing ports of each TURFIO are unpopulated.
    function automatic int lane_to_port(input int lane, input int per_tio, input int real_per_tio);
        return (lane / real_per_tio) * per_tio + (lane % real_per_tio);
    endfunction

endpackage

// File: rtl/surf_trig_deframer_if.sv
// surf_trig_if: raw SURF trigger input bus and the per-slot snapshot output.
//   slot_start      slot clock 0 marker
//   trig_dat        NSURF x 16-bit raw words, port p at [16p +: 16]
//   trig_dat_valid  per-port link valid
//   trig            per-lane trigger field, NREAL x TRIG_W
//   trig_meta       per-lane metadata, NREAL x META_W
//   trig_hit        per-lane hit flags
//   trig_valid      one-clock snapshot strobe
// master = source of raw words / consumer of snapshot; slave = deframer.
interface surf_trig_if
    import pueo_trig_in_pkg::*;
#(
    parameter int NSURF = 32,
    parameter int NLANE = NREAL
) ();

    logic                      slot_start;
    logic [NSURF*16-1:0]       trig_dat;
    logic [NSURF-1:0]          trig_dat_valid;
    logic [NLANE*TRIG_W-1:0]   trig;
    logic [NLANE*META_W-1:0]   trig_meta;
    logic [NLANE-1:0]          trig_hit;
    logic                      trig_valid;

    modport master (
        output slot_start, trig_dat, trig_dat_valid,
        input  trig, trig_meta, trig_hit, trig_valid
    );

    modport slave (
        input  slot_start, trig_dat, trig_dat_valid,
        output trig, trig_meta, trig_hit, trig_valid
    );

endinterface

// File: rtl/surf_trig_deframer_lane.sv
// surf_trig_lane_deframer: one real lane. Holds word0 and its link valid,
// then classifies against the live word1 presented during the word1 cycle.
//   clk, rst  system clock, synchronous active-high reset
//   cap0      latch word0 this cycle
//   word      live 16-bit word from this lane's port
//   valid     live link valid for this lane's port
//   mask      1 = lane forced idle
//   status    IDLE / HIT / FERR for (held word0, live word1)
//   trig      word0 trigger field when HIT, else 0
//   meta      word1 metadata when HIT, else 0
module surf_trig_lane_deframer
    import pueo_trig_in_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cap0,
    input  logic [15:0]         word,
    input  logic                valid,
    input  logic                mask,
    output lane_status_t        status,
    output logic [TRIG_W-1:0]   trig,
    output logic [META_W-1:0]   meta
);

    logic [15:0] w0;
    logic        v0;

    always_ff @(posedge clk) begin
        if (rst) begin
            w0 <= '0;
            v0 <= 1'b0;
        end else if (cap0) begin
            w0 <= word;
            v0 <= valid;
        end
    end

    always_comb begin
        status = IDLE;
        trig   = '0;
        meta   = '0;
        if (!mask && v0 && valid) begin
            if (w0 == 16'h0000 && word == 16'h0000) begin
                status = IDLE;
            end else if (w0[TRIG_FLAG_BIT] && !word[TRIG_FLAG_BIT]) begin
                status = HIT;
                trig   = w0[TRIG_W-1:0];
                meta   = word[META_W-1:0];
            end else begin
                status = FERR;
            end
        end
    end

endmodule

// File: rtl/surf_trig_deframer.sv
// surf_trig_deframer: pairs word0/word1 of each 4-clock trigger slot on the
// 28 populated SURF lanes, classifies them, registers one snapshot per slot
// and keeps framing-error statistics.
//   sysclk_i      system clock
//   sysclk_rst_i  synchronous active-high reset
//   bus           surf_trig_if slave: raw words in, snapshot out
//   lane_mask_i   1 = lane forced idle, sampled in the word1 cycle
//   err_clear_i   clears err_count_o, err_lanes_o, slot_err_o
//   err_count_o   saturating framing error count
//   err_lanes_o   sticky per-lane framing error flags
//   slot_err_o    sticky early-restart flag
module surf_trig_deframer
    import pueo_trig_in_pkg::*;
#(
    parameter int NSURF              = 32,
    parameter int SURFS_PER_TIO      = 8,
    parameter int REAL_SURFS_PER_TIO = 7
) (
    input  logic               sysclk_i,
    input  logic               sysclk_rst_i,
    surf_trig_if.slave         bus,
    input  logic [NREAL-1:0]   lane_mask_i,
    input  logic               err_clear_i,
    output logic [15:0]        err_count_o,
    output logic [NREAL-1:0]   err_lanes_o,
    output logic               slot_err_o
);

    // state   | meaning
    // ST_IDLE | waiting for slot_start; a start here captures word0
    // ST_W1   | word0 held; this cycle is word1 unless slot_start restarts

    localparam int NTIO   = NSURF / SURFS_PER_TIO;
    localparam int NSPARE = SURFS_PER_TIO - REAL_SURFS_PER_TIO;
    localparam int CNT_W  = $clog2(NREAL + 1);

    slot_state_t state, state_nxt;
    logic        cap0, cap1, restart;

    logic [NSURF*16-1:0]  dat;
    lane_status_t         lane_status [NREAL];
    logic [TRIG_W-1:0]    lane_trig   [NREAL];
    logic [META_W-1:0]    lane_meta   [NREAL];

    logic [NREAL-1:0]         hit_vec, ferr_vec;
    logic [NREAL*TRIG_W-1:0]  trig_nxt;
    logic [NREAL*META_W-1:0]  meta_nxt;
    logic [CNT_W-1:0]         n_err;
    logic [16:0]              err_sum;

    logic [NTIO*NSPARE-1:0]   unused_ports;

    assign dat = bus.trig_dat;

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap0      = 1'b0;
        cap1      = 1'b0;
        restart   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.slot_start) begin
                    cap0      = 1'b1;
                    state_nxt = ST_W1;
                end
            end
            ST_W1: begin
                if (bus.slot_start) begin
                    // Pending slot is dropped; this word starts a new slot.
                    cap0    = 1'b1;
                    restart = 1'b1;
                end else begin
                    cap1      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    for (genvar r = 0; r < NREAL; r++) begin : g_lane
        localparam int P = lane_to_port(r, SURFS_PER_TIO, REAL_SURFS_PER_TIO);
        surf_trig_lane_deframer u_lane (
            .clk    (sysclk_i),
            .rst    (sysclk_rst_i),
            .cap0   (cap0),
            .word   (dat[16*P +: 16]),
            .valid  (bus.trig_dat_valid[P]),
            .mask   (lane_mask_i[r]),
            .status (lane_status[r]),
            .trig   (lane_trig[r]),
            .meta   (lane_meta[r])
        );
    end

    // Unpopulated ports are intentionally dropped.
    for (genvar t = 0; t < NTIO; t++) begin : g_tio
        for (genvar s = 0; s < NSPARE; s++) begin : g_spare
            localparam int P = t * SURFS_PER_TIO + REAL_SURFS_PER_TIO + s;
            assign unused_ports[t*NSPARE + s] = ^{dat[16*P +: 16], bus.trig_dat_valid[P]};
        end
    end

    always_comb begin
        hit_vec  = '0;
        ferr_vec = '0;
        trig_nxt = '0;
        meta_nxt = '0;
        n_err    = '0;
        for (int r = 0; r < NREAL; r++) begin
            hit_vec[r]                    = (lane_status[r] == HIT);
            ferr_vec[r]                   = (lane_status[r] == FERR);
            trig_nxt[TRIG_W*r +: TRIG_W]  = lane_trig[r];
            meta_nxt[META_W*r +: META_W]  = lane_meta[r];
            n_err                         = n_err + CNT_W'(ferr_vec[r]);
        end
        err_sum = {1'b0, err_count_o} + 17'(n_err);
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            bus.trig_valid <= 1'b0;
            bus.trig       <= '0;
            bus.trig_meta  <= '0;
            bus.trig_hit   <= '0;
            err_count_o    <= '0;
            err_lanes_o    <= '0;
            slot_err_o     <= 1'b0;
        end else begin
            bus.trig_valid <= cap1;
            if (cap1) begin
                bus.trig      <= trig_nxt;
                bus.trig_meta <= meta_nxt;
                bus.trig_hit  <= hit_vec;
            end
            // Clear has priority over any same-cycle error update.
            if (err_clear_i) begin
                err_count_o <= '0;
                err_lanes_o <= '0;
                slot_err_o  <= 1'b0;
            end else begin
                if (cap1) begin
                    err_lanes_o <= err_lanes_o | ferr_vec;
                    err_count_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                end
                if (restart) slot_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_surf_trig_deframer.sv
// Testbench for surf_trig_deframer: table vectors, hand sequences for
// restart/clear/saturation/reset, and randomized slots against a
// behavioural model of the slot rules.
module tb_surf_trig_deframer;
    import pueo_trig_in_pkg::*;

    localparam int NS = 32;
    localparam int NR = 28;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     mask = '0;
    logic              clr = 1'b0;
    logic [15:0]       err_count;
    logic [NR-1:0]     err_lanes;
    logic              slot_err;

    surf_trig_if #(.NSURF(NS), .NLANE(NR)) bus ();

    surf_trig_deframer #(
        .NSURF(NS), .SURFS_PER_TIO(8), .REAL_SURFS_PER_TIO(7)
    ) dut (
        .sysclk_i     (clk),
        .sysclk_rst_i (rst),
        .bus          (bus),
        .lane_mask_i  (mask),
        .err_clear_i  (clr),
        .err_count_o  (err_count),
        .err_lanes_o  (err_lanes),
        .slot_err_o   (slot_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // model state
    int               m_count;
    logic [NR-1:0]    m_lanes;
    bit               m_slot_err;
    logic [NR-1:0]    e_hit;
    logic [NR*12-1:0] e_trig;
    logic [NR*8-1:0]  e_meta;

    typedef struct {
        int          port;
        logic [15:0] w0;
        logic [15:0] w1;
        bit          v0;
        bit          v1;
        int          mlane;
        int          lane;
        bit          exp_hit;
        bit          exp_err;
        logic [11:0] exp_trig;
        logic [7:0]  exp_meta;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_count = 0; m_lanes = '0; m_slot_err = 1'b0;
        e_hit = '0; e_trig = '0; e_meta = '0;
    endtask

    task automatic model_slot(input logic [NS*16-1:0] w0, input logic [NS*16-1:0] w1,
                              input logic [NS-1:0] v0, input logic [NS-1:0] v1,
                              input logic [NR-1:0] mk, input bit c);
        logic [NR-1:0] err;
        logic [15:0]   a, b;
        int            p;
        err = '0; e_hit = '0; e_trig = '0; e_meta = '0;
        for (int r = 0; r < NR; r++) begin
            p = (r / 7) * 8 + (r % 7);
            a = w0[16*p +: 16];
            b = w1[16*p +: 16];
            if (mk[r] || !v0[p] || !v1[p]) continue;
            if (a == 16'h0 && b == 16'h0) continue;
            if (a[15] && !b[15]) begin
                e_hit[r] = 1'b1;
                e_trig[12*r +: 12] = a[11:0];
                e_meta[8*r +: 8]   = b[7:0];
            end else begin
                err[r] = 1'b1;
            end
        end
        if (c) begin
            m_count = 0; m_lanes = '0; m_slot_err = 1'b0;
        end else begin
            m_count += $countones(err);
            if (m_count > 65535) m_count = 65535;
            m_lanes |= err;
        end
    endtask

    task automatic check_stats(input string tag);
        chk({tag, ".err_count"}, err_count, m_count[15:0]);
        chk({tag, ".err_lanes"}, err_lanes, m_lanes);
        chk({tag, ".slot_err"},  slot_err,  m_slot_err);
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".valid"}, bus.trig_valid, 1'b1);
        chk({tag, ".hit"},   bus.trig_hit,   e_hit);
        chk({tag, ".trig"},  bus.trig,       e_trig);
        chk({tag, ".meta"},  bus.trig_meta,  e_meta);
        check_stats(tag);
    endtask

    task automatic drive_idle();
        bus.slot_start     = 1'b0;
        bus.trig_dat       = '0;
        bus.trig_dat_valid = '1;
        clr                = 1'b0;
    endtask

    // Called at a negedge; drives word0 now, word1 next cycle, checks at T+2.
    task automatic apply_slot(input logic [NS*16-1:0] w0, input logic [NS*16-1:0] w1,
                              input logic [NS-1:0] v0, input logic [NS-1:0] v1,
                              input logic [NR-1:0] mk, input bit c, input int period,
                              input string tag, input bit do_chk);
        logic [NR-1:0] hold_hit;
        model_slot(w0, w1, v0, v1, mk, c);
        bus.slot_start = 1'b1; bus.trig_dat = w0; bus.trig_dat_valid = v0; mask = mk;
        @(negedge clk);
        bus.slot_start = 1'b0; bus.trig_dat = w1; bus.trig_dat_valid = v1; clr = c;
        @(negedge clk);
        drive_idle();
        if (do_chk) check_out(tag);
        hold_hit = e_hit;
        for (int i = 2; i < period; i++) begin
            @(negedge clk);
            if (do_chk && i == 2) begin
                chk({tag, ".strobe_once"}, bus.trig_valid, 1'b0);
                chk({tag, ".hit_hold"}, bus.trig_hit, hold_hit);
            end
        end
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_count = 0; m_lanes = '0; m_slot_err = 1'b0;
    endtask

    function automatic logic [NS*16-1:0] fill_all(input logic [15:0] w);
        logic [NS*16-1:0] v;
        for (int p = 0; p < NS; p++) v[16*p +: 16] = w;
        return v;
    endfunction

    initial begin
        logic [NS*16-1:0] w0, w1, bad;
        logic [NS-1:0]    v0, v1;
        logic [NR-1:0]    mk;
        int               typ;
        int               nstrobe;
        bit               c;

        tbl[0]  = '{9,  16'h8ABC, 16'h005A, 1, 1, -1,  8, 1, 0, 12'hABC, 8'h5A};
        tbl[1]  = '{7,  16'h8FFF, 16'h0000, 1, 1, -1, -1, 0, 0, 12'h000, 8'h00};
        tbl[2]  = '{3,  16'h1234, 16'h0000, 1, 1, -1,  3, 0, 1, 12'h000, 8'h00};
        tbl[3]  = '{22, 16'h0000, 16'h8001, 1, 1, -1, 20, 0, 1, 12'h000, 8'h00};
        tbl[4]  = '{3,  16'h1234, 16'h0000, 1, 1,  3,  3, 0, 0, 12'h000, 8'h00};
        tbl[5]  = '{3,  16'h1234, 16'h0000, 0, 1, -1,  3, 0, 0, 12'h000, 8'h00};
        tbl[6]  = '{3,  16'h1234, 16'h0000, 1, 0, -1,  3, 0, 0, 12'h000, 8'h00};
        tbl[7]  = '{31, 16'h8123, 16'h0001, 1, 1, -1, -1, 0, 0, 12'h000, 8'h00};
        tbl[8]  = '{30, 16'hF123, 16'h7F45, 1, 1, -1, 27, 1, 0, 12'h123, 8'h45};
        tbl[9]  = '{0,  16'h8000, 16'h0000, 1, 1, -1,  0, 1, 0, 12'h000, 8'h00};
        tbl[10] = '{11, 16'h0000, 16'h0001, 1, 1, -1, 10, 0, 1, 12'h000, 8'h00};
        tbl[11] = '{16, 16'h8001, 16'h8001, 1, 1, -1, 14, 0, 1, 12'h000, 8'h00};

        model_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.valid", bus.trig_valid, 1'b0);
        chk("reset.hit",   bus.trig_hit,   '0);
        chk("reset.trig",  bus.trig,       '0);
        chk("reset.meta",  bus.trig_meta,  '0);
        check_stats("reset");

        // idle slots
        for (int k = 0; k < 3; k++) begin
            apply_slot('0, '0, '1, '1, '0, 1'b0, 4, "idle", 1'b1);
            chk("idle.count_zero", err_count, 16'h0);
        end

        // table vectors, one active port each, statistics cleared first
        for (int i = 0; i < 12; i++) begin
            pulse_clear();
            w0 = '0; w1 = '0; v0 = '1; v1 = '1; mk = '0;
            w0[16*tbl[i].port +: 16] = tbl[i].w0;
            w1[16*tbl[i].port +: 16] = tbl[i].w1;
            v0[tbl[i].port] = tbl[i].v0;
            v1[tbl[i].port] = tbl[i].v1;
            if (tbl[i].mlane >= 0) mk[tbl[i].mlane] = 1'b1;
            apply_slot(w0, w1, v0, v1, mk, 1'b0, 4, $sformatf("tbl%0d", i), 1'b1);
            if (tbl[i].lane >= 0) begin
                chk($sformatf("tbl%0d.lane_hit", i), bus.trig_hit[tbl[i].lane], tbl[i].exp_hit);
                chk($sformatf("tbl%0d.lane_err", i), err_lanes,
                    tbl[i].exp_err ? (28'h1 << tbl[i].lane) : 28'h0);
                chk($sformatf("tbl%0d.cnt", i), err_count, {15'h0, tbl[i].exp_err});
                if (tbl[i].exp_hit) begin
                    chk($sformatf("tbl%0d.lane_trig", i), bus.trig[12*tbl[i].lane +: 12], tbl[i].exp_trig);
                    chk($sformatf("tbl%0d.lane_meta", i), bus.trig_meta[8*tbl[i].lane +: 8], tbl[i].exp_meta);
                end
            end else begin
                chk($sformatf("tbl%0d.no_hit", i), bus.trig_hit, '0);
                chk($sformatf("tbl%0d.no_err", i), err_lanes, '0);
            end
        end

        // two framing errors in one slot
        pulse_clear();
        w0 = '0; w1 = '0;
        w0[16*3 +: 16]  = 16'h1234;
        w1[16*22 +: 16] = 16'h8001;
        apply_slot(w0, w1, '1, '1, '0, 1'b0, 4, "two_err", 1'b1);
        chk("two_err.count", err_count, 16'd2);
        chk("two_err.lanes", err_lanes, (28'h1 << 3) | (28'h1 << 20));
        chk("two_err.hits",  bus.trig_hit, '0);

        // randomized slots
        for (int k = 0; k < 60; k++) begin
            for (int p = 0; p < NS; p++) begin
                typ = $urandom_range(0, 3);
                case (typ)
                    0: begin w0[16*p +: 16] = 16'h0; w1[16*p +: 16] = 16'h0; end
                    1: begin
                        w0[16*p +: 16] = 16'($urandom) | 16'h8000;
                        w1[16*p +: 16] = 16'($urandom) & 16'h7FFF;
                    end
                    default: begin
                        w0[16*p +: 16] = 16'($urandom);
                        w1[16*p +: 16] = 16'($urandom);
                    end
                endcase
                v0[p] = ($urandom_range(0, 15) != 0);
                v1[p] = ($urandom_range(0, 15) != 0);
            end
            for (int r = 0; r < NR; r++) mk[r] = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 9) == 0);
            apply_slot(w0, w1, v0, v1, mk, c, $urandom_range(2, 5), $sformatf("rnd%0d", k), 1'b1);
        end
        repeat (2) @(negedge clk);

        // early restart: start on two consecutive clocks
        bad = fill_all(16'h1234);
        w0 = '0; w0[15:0] = 16'h8001;
        w1 = '0; w1[15:0] = 16'h0022;
        model_slot(w0, w1, '1, '1, '0, 1'b0);
        m_slot_err = 1'b1;
        mask = '0;
        bus.slot_start = 1'b1; bus.trig_dat = bad; bus.trig_dat_valid = '1;
        @(negedge clk);
        chk("restart.no_strobe_a", bus.trig_valid, 1'b0);
        bus.trig_dat = w0;
        @(negedge clk);
        chk("restart.no_strobe_b", bus.trig_valid, 1'b0);
        chk("restart.slot_err_early", slot_err, 1'b1);
        bus.slot_start = 1'b0; bus.trig_dat = w1;
        @(negedge clk);
        drive_idle();
        check_out("restart");
        nstrobe = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.trig_valid) nstrobe++;
        end
        chk("restart.single_strobe", nstrobe, 0);

        // standalone clear
        pulse_clear();
        check_stats("clear");

        // clear coinciding with an all-lane error slot
        apply_slot(bad, '0, '1, '1, '0, 1'b0, 4, "err_all", 1'b1);
        apply_slot(bad, '0, '1, '1, '0, 1'b1, 4, "clr_wins", 1'b1);
        chk("clr_wins.count", err_count, 16'h0);
        chk("clr_wins.lanes", err_lanes, '0);

        // saturation: 2340*28 + 14 = 0xFFFE, then a full error slot
        pulse_clear();
        for (int k = 0; k < 2340; k++)
            apply_slot(bad, '0, '1, '1, '0, 1'b0, 2, "sat_fill", 1'b0);
        apply_slot(bad, '0, '1, '1, 28'hFFFC000, 1'b0, 4, "sat_pre", 1'b1);
        chk("sat.preload", err_count, 16'hFFFE);
        apply_slot(bad, '0, '1, '1, '0, 1'b0, 4, "sat_top", 1'b1);
        chk("sat.top", err_count, 16'hFFFF);
        apply_slot(bad, '0, '1, '1, '0, 1'b0, 4, "sat_hold", 1'b1);
        chk("sat.hold", err_count, 16'hFFFF);

        // reset during the word1 cycle
        w0 = '0; w0[16*9 +: 16] = 16'h8ABC;
        w1 = '0; w1[16*9 +: 16] = 16'h005A;
        mask = '0;
        bus.slot_start = 1'b1; bus.trig_dat = w0; bus.trig_dat_valid = '1;
        @(negedge clk);
        bus.slot_start = 1'b0; bus.trig_dat = w1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        model_reset();
        chk("rst_mid.valid", bus.trig_valid, 1'b0);
        chk("rst_mid.hit",   bus.trig_hit,   '0);
        chk("rst_mid.trig",  bus.trig,       '0);
        chk("rst_mid.meta",  bus.trig_meta,  '0);
        check_stats("rst_mid");
        @(negedge clk);
        chk("rst_mid.no_late_strobe", bus.trig_valid, 1'b0);
        apply_slot(w0, w1, '1, '1, '0, 1'b0, 4, "after_rst", 1'b1);
        chk("after_rst.lane8_trig", bus.trig[12*8 +: 12], 12'hABC);
        chk("after_rst.lane8_meta", bus.trig_meta[8*8 +: 8], 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
